// File: rtl/base_row_gather.sv
// Row-to-matrix gather: collects rs rows of cs w-bit words into one matrix beat.
// Define BASE_GATHER_TRANSPOSE_EN to present o_d column-major instead of row-major.
module base_row_gather #(
  parameter int w  = 1,
  parameter int rs = 1,
  parameter int cs = 1
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  i_v,
  output logic                                  i_r,
  input  logic [0:w*cs-1]                       i_d,
  output logic                                  o_v,
  input  logic                                  o_r,
  output logic [0:w*rs*cs-1]                    o_d,
  output logic [((rs > 1) ? $clog2(rs) : 1)-1:0] o_rcnt
);

  localparam int CntW = (rs > 1) ? $clog2(rs) : 1;
  localparam int RowW = w * cs;
  localparam logic [CntW-1:0] LastRow = CntW'(rs - 1);

  logic [CntW-1:0]     rcnt_q, rcnt_d;
  logic                valid_q, valid_d;
  logic [0:w*rs*cs-1]  mat_q, mat_d;
  logic                inFire;
  logic                outFire;

  assign i_r     = !valid_q | o_r;
  assign inFire  = i_v & i_r;
  assign outFire = valid_q & o_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt_q  <= '0;
      valid_q <= 1'b0;
      mat_q   <= '0;
    end else begin
      rcnt_q  <= rcnt_d;
      valid_q <= valid_d;
      mat_q   <= mat_d;
    end
  end

  // A drain and a fill may share an edge; the fill's completion wins for rs = 1.
  always_comb begin
    rcnt_d  = rcnt_q;
    valid_d = valid_q;
    mat_d   = mat_q;
    if (outFire) begin
      valid_d = 1'b0;
    end
    if (inFire) begin
      for (int r = 0; r < rs; r++) begin
        if (rcnt_q == CntW'(r)) begin
          mat_d[r*RowW +: RowW] = i_d;
        end
      end
      if (rcnt_q == LastRow) begin
        rcnt_d  = '0;
        valid_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + CntW'(1);
      end
    end
  end

  assign o_v    = valid_q;
  assign o_rcnt = rcnt_q;

`ifdef BASE_GATHER_TRANSPOSE_EN
  always_comb begin
    o_d = '0;
    for (int r = 0; r < rs; r++) begin
      for (int c = 0; c < cs; c++) begin
        o_d[(rs*c + r)*w +: w] = mat_q[(cs*r + c)*w +: w];
      end
    end
  end
`else
  assign o_d = mat_q;
`endif

endmodule

// File: tb/tb_base_row_gather.sv
// Directed bench for base_row_gather: a 2x3 byte matrix instance and a 1x2 instance.
module tb_base_row_gather;

  logic clk = 1'b0;
  logic reset_n;

  logic         aIv, aIr, aOv, aOr;
  logic [0:23]  aId;
  logic [0:47]  aOd;
  logic [0:0]   aRcnt;

  logic         bIv, bIr, bOv, bOr;
  logic [0:15]  bId;
  logic [0:15]  bOd;
  logic [0:0]   bRcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  base_row_gather #(.w(8), .rs(2), .cs(3)) dutA (
    .clk(clk), .reset_n(reset_n),
    .i_v(aIv), .i_r(aIr), .i_d(aId),
    .o_v(aOv), .o_r(aOr), .o_d(aOd), .o_rcnt(aRcnt)
  );

  base_row_gather #(.w(8), .rs(1), .cs(2)) dutB (
    .clk(clk), .reset_n(reset_n),
    .i_v(bIv), .i_r(bIr), .i_d(bId),
    .o_v(bOv), .o_r(bOr), .o_d(bOd), .o_rcnt(bRcnt)
  );

  // Expected 2x3 matrix image in the layout selected by the build.
  function automatic logic [0:47] expMat(input logic [0:23] r0, input logic [0:23] r1);
`ifdef BASE_GATHER_TRANSPOSE_EN
    return {r0[0:7], r1[0:7], r0[8:15], r1[8:15], r0[16:23], r1[16:23]};
`else
    return {r0, r1};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (aOv !== 1'b0) begin errors++; $display("[TB] FAIL reset_a_ov: got %b expected 0", aOv); end
    checks++; if (aIr !== 1'b1) begin errors++; $display("[TB] FAIL reset_a_ir: got %b expected 1", aIr); end
    checks++; if (aOd !== 48'h0) begin errors++; $display("[TB] FAIL reset_a_od: got %h expected 0", aOd); end
    checks++; if (aRcnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_a_rcnt: got %h expected 0", aRcnt); end
    checks++; if (bOv !== 1'b0) begin errors++; $display("[TB] FAIL reset_b_ov: got %b expected 0", bOv); end
    checks++; if (bIr !== 1'b1) begin errors++; $display("[TB] FAIL reset_b_ir: got %b expected 1", bIr); end
  endtask

  task automatic test_fill();
    logic [0:47] want;
`ifdef BASE_GATHER_TRANSPOSE_EN
    want = 48'h010402050306;
`else
    want = 48'h010203040506;
`endif
    aIv = 1'b1; aOr = 1'b1; aId = 24'h010203;
    tick();
    checks++; if (aOv !== 1'b0) begin errors++; $display("[TB] FAIL fill_ov_row0: got %b expected 0", aOv); end
    checks++; if (aRcnt !== 1'b1) begin errors++; $display("[TB] FAIL fill_rcnt_row0: got %h expected 1", aRcnt); end
    aId = 24'h040506;
    tick();
    aIv = 1'b0; aOr = 1'b0;
    checks++; if (aOv !== 1'b1) begin errors++; $display("[TB] FAIL fill_ov: got %b expected 1", aOv); end
    checks++; if (aOd !== want) begin errors++; $display("[TB] FAIL fill_od: got %h expected %h", aOd, want); end
    checks++; if (aRcnt !== 1'b0) begin errors++; $display("[TB] FAIL fill_rcnt_wrap: got %h expected 0", aRcnt); end
  endtask

  task automatic test_stall();
    logic [0:47] held;
    logic [0:47] next;
    held = expMat(24'h010203, 24'h040506);
    next = expMat(24'h0A0B0C, 24'h0D0E0F);
    aIv = 1'b1; aOr = 1'b0; aId = 24'h0A0B0C;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (aIr !== 1'b0) begin errors++; $display("[TB] FAIL stall_ir[%0d]: got %b expected 0", i, aIr); end
      checks++; if (aOv !== 1'b1) begin errors++; $display("[TB] FAIL stall_ov[%0d]: got %b expected 1", i, aOv); end
      checks++; if (aOd !== held) begin errors++; $display("[TB] FAIL stall_od[%0d]: got %h expected %h", i, aOd, held); end
      tick();
    end
    aOr = 1'b1;
    #1;
    checks++; if (aIr !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_ir: got %b expected 1", aIr); end
    tick();
    checks++; if (aOv !== 1'b0) begin errors++; $display("[TB] FAIL stall_drain_ov: got %b expected 0", aOv); end
    checks++; if (aRcnt !== 1'b1) begin errors++; $display("[TB] FAIL stall_row0_taken: got %h expected 1", aRcnt); end
    aId = 24'h0D0E0F;
    tick();
    checks++; if (aOv !== 1'b1) begin errors++; $display("[TB] FAIL stall_next_ov: got %b expected 1", aOv); end
    checks++; if (aOd !== next) begin errors++; $display("[TB] FAIL stall_next_od: got %h expected %h", aOd, next); end
    aIv = 1'b0;
    tick();
    checks++; if (aOv !== 1'b0) begin errors++; $display("[TB] FAIL stall_final_drain: got %b expected 0", aOv); end
  endtask

  task automatic test_back_to_back();
    logic [0:23] rowTab [8];
    logic [0:47] want;
    int beats = 0;
    for (int i = 0; i < 8; i++) begin
      rowTab[i] = {8'(i*16 + 1), 8'(i*16 + 2), 8'(i*16 + 3)};
    end
    aIv = 1'b1; aOr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      aId = rowTab[i];
      #1;
      checks++; if (aIr !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ir[%0d]: got %b expected 1", i, aIr); end
      tick();
      if (aOv === 1'b1) beats++;
      checks++;
      if (aOv !== ((i % 2) == 1)) begin
        errors++; $display("[TB] FAIL b2b_ov[%0d]: got %b expected %b", i, aOv, (i % 2) == 1);
      end
      if ((i % 2) == 1) begin
        want = expMat(rowTab[i-1], rowTab[i]);
        checks++; if (aOd !== want) begin errors++; $display("[TB] FAIL b2b_od[%0d]: got %h expected %h", i, aOd, want); end
      end
    end
    aIv = 1'b0;
    tick();
    checks++; if (aOv !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b expected 0", aOv); end
    checks++; if (beats !== 4) begin errors++; $display("[TB] FAIL b2b_beats: got %0d expected 4", beats); end
  endtask

  task automatic test_reset_mid_fill();
    logic [0:47] want;
    want = expMat(24'h222222, 24'h333333);
    aIv = 1'b1; aOr = 1'b0; aId = 24'h111111;
    tick();
    checks++; if (aRcnt !== 1'b1) begin errors++; $display("[TB] FAIL midrst_partial: got %h expected 1", aRcnt); end
    aIv = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++; if (aRcnt !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rcnt: got %h expected 0", aRcnt); end
    checks++; if (aOd !== 48'h0) begin errors++; $display("[TB] FAIL midrst_od: got %h expected 0", aOd); end
    #2;
    reset_n = 1'b1;
    aIv = 1'b1; aId = 24'h222222;
    tick();
    checks++; if (aOv !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ov_early: got %b expected 0", aOv); end
    aId = 24'h333333;
    tick();
    aIv = 1'b0;
    checks++; if (aOv !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ov: got %b expected 1", aOv); end
    checks++; if (aOd !== want) begin errors++; $display("[TB] FAIL midrst_od_new: got %h expected %h", aOd, want); end
    aOr = 1'b1;
    tick();
    aOr = 1'b0;
  endtask

  task automatic test_single_row();
    bIv = 1'b1; bOr = 1'b1; bId = 16'hAA55;
    tick();
    checks++; if (bOv !== 1'b1) begin errors++; $display("[TB] FAIL rs1_ov0: got %b expected 1", bOv); end
    checks++; if (bOd !== 16'hAA55) begin errors++; $display("[TB] FAIL rs1_od0: got %h expected aa55", bOd); end
    bId = 16'h1234;
    #1;
    checks++; if (bIr !== 1'b1) begin errors++; $display("[TB] FAIL rs1_ir: got %b expected 1", bIr); end
    tick();
    checks++; if (bOv !== 1'b1) begin errors++; $display("[TB] FAIL rs1_ov1: got %b expected 1", bOv); end
    checks++; if (bOd !== 16'h1234) begin errors++; $display("[TB] FAIL rs1_od1: got %h expected 1234", bOd); end
    checks++; if (bRcnt !== 1'b0) begin errors++; $display("[TB] FAIL rs1_rcnt: got %h expected 0", bRcnt); end
    bIv = 1'b0;
    tick();
    checks++; if (bOv !== 1'b0) begin errors++; $display("[TB] FAIL rs1_drain: got %b expected 0", bOv); end
  endtask

  initial begin
    reset_n = 1'b0;
    aIv = 1'b0; aOr = 1'b0; aId = '0;
    bIv = 1'b0; bOr = 1'b0; bId = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    test_reset();
    test_fill();
    test_stall();
    test_back_to_back();
    test_reset_mid_fill();
    test_single_row();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/base_row_gather.md
Name: base_row_gather

Overview:
- Streaming front-end for the transpose cell.
- Accepts one matrix row per valid/ready beat and assembles rs rows of cs words, each w bits wide, into one full-matrix register.
- Presents the whole matrix as a single output beat, in row-major order, which is exactly the layout the transpose cell takes as its input.
- Sits directly upstream of the transpose cell in matrix-reshaping pipelines.

Parameters:
- w, 1, width of one matrix element in bits
- rs, 1, rows per matrix (input beats per output beat)
- cs, 1, columns per matrix (elements per input beat)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- i_v  input  1  input row valid
- i_r  output  1  input row ready
- i_d  input  w*cs  one row; element c is at bits [c*w : (c+1)*w-1]; bit 0 is the MSB side, [0:N-1] ordering
- o_v  output  1  assembled matrix valid
- o_r  input  1  downstream ready
- o_d  output  w*rs*cs  matrix; element (r,c) is at bits [(cs*r+c)*w : (cs*r+c+1)*w-1]
- o_rcnt  output  max(1,$clog2(rs))  number of rows currently buffered toward the next matrix (debug)

Behaviour:
- Reset, asserted asynchronously:
  - row counter = 0, o_v = 0, o_rcnt = 0.
  - Matrix register cleared to 0, so o_d = 0.
  - i_r = 1 as soon as reset_n deasserts.
- Transfer rules:
  - An input transfer occurs on a cycle where i_v and i_r are both 1.
  - An output transfer occurs on a cycle where o_v and o_r are both 1.
  - i_d is not sampled when i_v = 0.
- States (implicit in row counter and o_v):
  - FILL: o_v = 0 and counter = k.
    - Each input transfer writes i_d into row k and increments the counter.
    - The transfer that writes row rs-1 wraps the counter to 0 and sets o_v = 1 on the next cycle.
    - Latency: o_v rises one cycle after the last row is accepted.
  - FULL: o_v = 1.
    - o_d and o_v are held stable until an output transfer occurs; o_d is held unchanged while o_r = 0.
- Ready:
  - i_r = !o_v | o_r (combinational from o_r).
- Simultaneous drain and fill:
  - An output transfer and an input transfer may occur in the same cycle.
  - The new row is written into row 0; the old o_d is consumed at that same edge.
  - o_v clears on the next cycle, unless rs = 1, in which case o_v stays 1 with the new data.
  - This sustains full throughput: one matrix every rs cycles, no bubbles.
- rs = 1: every accepted beat completes a matrix; the counter stays at 0.
- Rows not yet overwritten keep their previous contents. Only complete matrices are ever flagged valid.
- Reset mid-fill: any partial matrix is discarded; the counter returns to 0.
- No overflow is possible: the block never accepts a row while holding an unconsumed full matrix unless that matrix drains the same cycle.

Optional Feature:
- Macro: BASE_GATHER_TRANSPOSE_EN
- Defined:
  - A transpose stage is instantiated on the output. o_d becomes column-major: element (r,c) is at bits [(rs*c+r)*w : (rs*c+r+1)*w-1].
  - The transpose is combinational and adds zero latency; handshakes are unchanged.
- Undefined: o_d is row-major as specified above.

Test Plan (w=8, rs=2, cs=3 unless noted):
- Reset then idle -> o_v=0, i_r=1, o_d=0, o_rcnt=0.
- Rows 0x010203, then 0x040506, o_r=1 -> one cycle after the second accept, o_v=1 and o_d=0x010203040506. With BASE_GATHER_TRANSPOSE_EN defined, o_d=0x010402050306.
- Matrix full, o_r=0 for 5 cycles with i_v=1 -> i_r=0 and o_d stable for all 5 cycles; on o_r=1, i_r=1 and row 0 is accepted in the same cycle.
- Continuous i_v=1 and o_r=1 over 4 matrices -> exactly one output beat every 2 cycles; all data in order.
- Assert reset_n=0 after 1 row, then send 2 new rows -> output contains only the 2 new rows.
- rs=1, cs=2, i_v=o_r=1 with beats 0xAA55, 0x1234 -> o_v stays 1 from cycle 1 and o_d follows each beat one cycle later.
